// File: rtl/fish_pkg.sv
// Shared types and helpers for the multi-lane SRAM buffer.
package fish_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Low bit of lane k inside a packed multi-lane word.
    function automatic int lane_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/mlane_sram_rdreg.sv
// Read output register: captures the addressed word on accept and holds it
// until the consumer takes it.
module mlane_sram_rdreg #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_rd_valid,
    input  logic             i_rd_ready,
    input  logic [WIDTH-1:0] i_rd_word,
    output logic             o_rd_ready,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept;

    assign o_rd_ready = i_run && (!valid_q || i_rd_ready);
    assign accept     = o_rd_ready && i_rd_valid;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = i_rd_word;
        end else if (i_rd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_rd_valid = valid_q;
    assign o_rd_data  = data_q;

endmodule

// File: rtl/mlane_sram.sv
// Multi-lane single-clock SRAM buffer: LANES-word masked writes with modulo
// wrap, single-word handshaked reads, optional clear after reset.
module mlane_sram
    import fish_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int DEPTH      = 128,
    parameter int LANES      = 4,
    parameter int INIT_CLEAR = 1,
    parameter int ADDRB      = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic                   i_wr_auto,
    input  logic [ADDRB-1:0]       i_wr_addr,
    input  logic [LANES-1:0]       i_wr_mask,
    input  logic [LANES*WIDTH-1:0] i_wr_data,
    output logic [ADDRB-1:0]       o_wr_ptr,
    output logic                   o_wr_err,
    input  logic                   i_rd_valid,
    output logic                   o_rd_ready,
    input  logic [ADDRB-1:0]       i_rd_addr,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_busy
);

    localparam logic [ADDRB:0] DEPTH_E = (ADDRB+1)'(DEPTH);
    localparam logic [ADDRB:0] LANES_E = (ADDRB+1)'(LANES);

    // Both operands are below DEPTH, so one conditional subtract wraps.
    function automatic logic [ADDRB:0] mod_add(input logic [ADDRB:0] a,
                                               input logic [ADDRB:0] b);
        logic [ADDRB:0] s;
        s = a + b;
        if (s >= DEPTH_E)
            s = s - DEPTH_E;
        return s;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q;
    logic             busy_q;
    logic             err_q;
    logic [ADDRB-1:0] wr_ptr_q;
    logic [ADDRB-1:0] clr_base_q;

    logic             run;
    logic             clr_en;
    logic             clr_last;
    logic             wr_bad;
    logic             wr_acc;
    logic [ADDRB-1:0] wr_base;
    logic [ADDRB-1:0] lane_addr [LANES];
    logic [ADDRB-1:0] clr_addr  [LANES];
    logic [LANES-1:0] clr_ok;
    logic [WIDTH-1:0] rd_word;

    assign run      = (state_q == S_RUN);
    assign clr_en   = (state_q == S_INIT) && !i_rst;
    assign clr_last = ({1'b0, clr_base_q} + LANES_E) >= DEPTH_E;
    assign wr_base  = i_wr_auto ? wr_ptr_q : i_wr_addr;
    assign wr_bad   = !i_wr_auto && ({1'b0, i_wr_addr} >= DEPTH_E);
    assign wr_acc   = run && i_wr_en && !wr_bad;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ADDRB:0] clr_sum;
            assign lane_addr[gi] = ADDRB'(mod_add({1'b0, wr_base}, (ADDRB+1)'(gi)));
            assign clr_sum       = {1'b0, clr_base_q} + (ADDRB+1)'(gi);
            assign clr_ok[gi]    = clr_sum < DEPTH_E;
            assign clr_addr[gi]  = clr_sum[ADDRB-1:0];
        end
    endgenerate

    // Clear and write never overlap: one happens only in S_INIT, the other in S_RUN.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (clr_en && clr_ok[k])
                mem[clr_addr[k]] <= '0;
            else if (wr_acc && i_wr_mask[k])
                mem[lane_addr[k]] <= i_wr_data[lane_lo(k, WIDTH) +: WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
            busy_q     <= (INIT_CLEAR != 0);
            clr_base_q <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= run && i_wr_en && wr_bad;
            case (state_q)
                S_INIT: begin
                    if (clr_last) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_base_q <= clr_base_q + ADDRB'(LANES);
                    end
                end
                S_RUN: begin
                    if (i_wr_en && i_wr_auto)
                        wr_ptr_q <= ADDRB'(mod_add({1'b0, wr_ptr_q}, LANES_E));
                end
            endcase
        end
    end

    // Combinational array read feeds the registered output stage (read-first).
    assign rd_word = ({1'b0, i_rd_addr} < DEPTH_E) ? mem[i_rd_addr] : '0;

    mlane_sram_rdreg #(
        .WIDTH(WIDTH)
    ) u_rdreg (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_run      (run),
        .i_rd_valid (i_rd_valid),
        .i_rd_ready (i_rd_ready),
        .i_rd_word  (rd_word),
        .o_rd_ready (o_rd_ready),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data)
    );

    assign o_wr_ptr = wr_ptr_q;
    assign o_wr_err = err_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_mlane_sram.sv
// Randomised bench for mlane_sram against a word-array reference model, plus
// directed checks on a non-power-of-two build.
module tb_mlane_sram;

    localparam int W    = 10;
    localparam int D    = 128;
    localparam int L    = 4;
    localparam int AB   = 7;
    localparam int NCLR = (D + L - 1) / L;
    localparam int BD   = 100;

    logic          clk;
    logic          rst, wr_en, wr_auto, rd_valid, rd_ready;
    logic [AB-1:0] wr_addr, rd_addr, wr_ptr;
    logic [L-1:0]  wr_mask;
    logic [L*W-1:0] wr_data;
    logic          wr_err, rd_ready_o, rd_valid_o, busy;
    logic [W-1:0]  rd_data;

    logic          b_rst, b_wr_en, b_wr_auto, b_rd_valid, b_rd_ready;
    logic [AB-1:0] b_wr_addr, b_rd_addr, b_wr_ptr;
    logic [L-1:0]  b_wr_mask;
    logic [L*W-1:0] b_wr_data;
    logic          b_wr_err, b_rd_ready_o, b_rd_valid_o, b_busy;
    logic [W-1:0]  b_rd_data;

    int n_vec = 0;
    int n_err = 0;

    int m_mem [D];
    int m_ptr, m_err, m_valid, m_data, m_busy, m_left;

    mlane_sram #(.WIDTH(W), .DEPTH(D), .LANES(L), .INIT_CLEAR(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_auto(wr_auto),
        .i_wr_addr(wr_addr), .i_wr_mask(wr_mask), .i_wr_data(wr_data),
        .o_wr_ptr(wr_ptr), .o_wr_err(wr_err), .i_rd_valid(rd_valid),
        .o_rd_ready(rd_ready_o), .i_rd_addr(rd_addr), .o_rd_valid(rd_valid_o),
        .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_busy(busy)
    );

    mlane_sram #(.WIDTH(W), .DEPTH(BD), .LANES(L), .INIT_CLEAR(0)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_wr_en(b_wr_en), .i_wr_auto(b_wr_auto),
        .i_wr_addr(b_wr_addr), .i_wr_mask(b_wr_mask), .i_wr_data(b_wr_data),
        .o_wr_ptr(b_wr_ptr), .o_wr_err(b_wr_err), .i_rd_valid(b_rd_valid),
        .o_rd_ready(b_rd_ready_o), .i_rd_addr(b_rd_addr), .o_rd_valid(b_rd_valid_o),
        .i_rd_ready(b_rd_ready), .o_rd_data(b_rd_data), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of the main DUT: reference model advances by the spec rules.
    task automatic step();
        int base;
        #1;
        check("rd_ready", 32'(rd_ready_o), (!m_busy && (!m_valid || rd_ready)) ? 1 : 0);
        @(posedge clk);
        if (rst) begin
            m_busy = 1; m_left = NCLR; m_valid = 0; m_data = 0; m_ptr = 0; m_err = 0;
            for (int i = 0; i < D; i++) m_mem[i] = 0;
        end else if (m_busy) begin
            m_err = 0;
            m_left--;
            if (m_left == 0) m_busy = 0;
        end else begin
            if (rd_valid && (!m_valid || rd_ready)) begin
                m_data  = m_mem[rd_addr];
                m_valid = 1;
            end else if (rd_ready) begin
                m_valid = 0;
            end
            m_err = 0;
            if (wr_en) begin
                if (!wr_auto && int'(wr_addr) >= D) begin
                    m_err = 1;
                end else begin
                    base = wr_auto ? m_ptr : int'(wr_addr);
                    for (int k = 0; k < L; k++)
                        if (wr_mask[k]) m_mem[(base + k) % D] = int'(wr_data[k*W +: W]);
                    if (wr_auto) m_ptr = (m_ptr + L) % D;
                end
            end
        end
        @(negedge clk);
        check("busy",     32'(busy),       m_busy);
        check("rd_valid", 32'(rd_valid_o), m_valid);
        check("rd_data",  32'(rd_data),    m_data);
        check("wr_ptr",   32'(wr_ptr),     m_ptr);
        check("wr_err",   32'(wr_err),     m_err);
    endtask

    task automatic idle();
        wr_en = 0; wr_auto = 0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_valid = 0; rd_addr = '0; rd_ready = 1;
    endtask

    task automatic do_reset_and_clear();
        int n;
        rst = 1; step(); rst = 0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
        check("busy_len", n, NCLR);
        $display("reset: busy for %0d cycles", n);
    endtask

    task automatic wr(input logic auto_b, input int addr, input logic [L-1:0] mask,
                      input logic [L*W-1:0] data);
        wr_en = 1; wr_auto = auto_b; wr_addr = AB'(addr); wr_mask = mask; wr_data = data;
        step();
        wr_en = 0;
        $display("wr auto=%0d addr=%0d mask=%b ptr=%0d", auto_b, addr, mask, wr_ptr);
    endtask

    task automatic rd(input int addr, output int data);
        rd_valid = 1; rd_addr = AB'(addr); rd_ready = 1;
        step();
        rd_valid = 0;
        check("rd_lat_valid", 32'(rd_valid_o), 1);
        data = int'(rd_data);
        $display("rd addr=%0d data=%03h", addr, data);
    endtask

    task automatic b_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic b_rd(input int addr, output int data);
        b_rd_valid = 1; b_rd_addr = AB'(addr); b_rd_ready = 1;
        b_step();
        b_rd_valid = 0;
        check("b_rd_valid", 32'(b_rd_valid_o), 1);
        data = int'(b_rd_data);
        $display("b rd addr=%0d data=%03h", addr, data);
    endtask

    initial begin
        int d, old;
        rst = 1; idle();
        b_rst = 1; b_wr_en = 0; b_wr_auto = 0; b_wr_addr = '0; b_wr_mask = '0;
        b_wr_data = '0; b_rd_valid = 0; b_rd_addr = '0; b_rd_ready = 1;
        m_busy = 1; m_left = NCLR; m_valid = 0; m_data = 0; m_ptr = 0; m_err = 0;
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        @(negedge clk);

        // Non-power-of-two build, no clear engine.
        b_step(); b_rst = 0;
        check("b_busy",   32'(b_busy),       0);
        check("b_ptr0",   32'(b_wr_ptr),     0);
        check("b_valid0", 32'(b_rd_valid_o), 0);
        check("b_data0",  32'(b_rd_data),    0);
        check("b_ready0", 32'(b_rd_ready_o), 1);
        b_wr_en = 1; b_wr_addr = 7'd98; b_wr_mask = 4'hF;
        b_wr_data = {10'h044, 10'h333, 10'h222, 10'h111};
        b_step();
        check("b_err_ok", 32'(b_wr_err), 0);
        b_wr_addr = 7'd100; b_wr_data = {4{10'h3FF}};
        b_step();
        b_wr_en = 0;
        check("b_err_pulse", 32'(b_wr_err), 1);
        b_step();
        check("b_err_clear", 32'(b_wr_err), 0);
        b_rd(98, d);  check("b_rd98", d, 32'h111);
        b_rd(99, d);  check("b_rd99", d, 32'h222);
        b_rd(0, d);   check("b_rd0",  d, 32'h333);
        b_rd(1, d);   check("b_rd1",  d, 32'h044);
        b_rd(110, d); check("b_rd_oob", d, 0);
        b_wr_en = 1; b_wr_auto = 1; b_wr_mask = '0;
        for (int i = 0; i < 26; i++) b_step();
        b_wr_en = 0;
        check("b_ptr_wrap", 32'(b_wr_ptr), 4);

        // Main build: clear engine then directed cases.
        do_reset_and_clear();
        rd(5, d); check("rd5_cleared", d, 0);

        wr(0, 10, 4'b1011, {10'h004, 10'h003, 10'h002, 10'h001});
        rd(10, d); check("rd10", d, 32'h001);
        rd(11, d); check("rd11", d, 32'h002);
        rd(12, d); check("rd12", d, 32'h000);
        rd(13, d); check("rd13", d, 32'h004);

        wr(0, 126, 4'hF, {10'h1DD, 10'h1CC, 10'h1BB, 10'h1AA});
        check("ptr_explicit", 32'(wr_ptr), 0);
        rd(126, d); check("rd126", d, 32'h1AA);
        rd(127, d); check("rd127", d, 32'h1BB);
        rd(0, d);   check("rd0",   d, 32'h1CC);
        rd(1, d);   check("rd1",   d, 32'h1DD);

        for (int i = 0; i < 40; i++)
            wr(1, 0, 4'($urandom), 40'({$urandom(), $urandom()}));
        check("ptr_40beats", 32'(wr_ptr), 32);

        // Held read while the word is rewritten underneath.
        old = m_mem[7];
        rd_valid = 1; rd_addr = 7'd7; rd_ready = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_auto = 0; wr_addr = 7'd7; wr_mask = 4'b0001;
            wr_data = 40'({$urandom(), $urandom()});
            step();
            check("hold_data",  32'(rd_data), old);
            check("hold_ready", 32'(rd_ready_o), 0);
        end
        wr_en = 0; rd_valid = 0; rd_ready = 1;
        step();
        old = m_mem[7];
        rd_valid = 1; rd_addr = 7'd7;
        wr_en = 1; wr_auto = 0; wr_addr = 7'd7; wr_mask = 4'b0001; wr_data = 40'h2A5;
        step();
        wr_en = 0; rd_valid = 0;
        check("read_first", 32'(rd_data), old);
        rd(7, d); check("after_write", d, 32'h2A5);

        // Reset in the middle of the clear, then during a held read.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 10; i++) step();
        do_reset_and_clear();
        wr(1, 0, 4'hF, 40'h0);
        rd_valid = 1; rd_addr = 7'd3; rd_ready = 0;
        step();
        rd_valid = 0;
        rst = 1; step();
        check("rst_valid", 32'(rd_valid_o), 0);
        check("rst_ptr",   32'(wr_ptr), 0);
        rst = 0; rd_ready = 1;
        begin : post_rst
            int n;
            n = 1;
            while (busy === 1'b1 && n < 200) begin
                step();
                if (busy === 1'b1) n++;
            end
            check("rst_busy_len", n, NCLR);
        end

        // Randomised traffic, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            wr_en    = 1'($urandom);
            wr_auto  = 1'($urandom);
            wr_addr  = 7'($urandom);
            wr_mask  = 4'($urandom);
            wr_data  = 40'({$urandom(), $urandom()});
            rd_valid = 1'($urandom);
            rd_addr  = 7'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
